// File: rtl/gb_io_pkg.sv
// Shared definitions for the GB I/O pad arbiter: FSM state encoding and
// the default pad read latency.
package gb_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN,
        WAIT_RD,
        DONE
    } state_t;

    localparam int RD_LAT_DEFAULT = 2;

endpackage

// File: rtl/gb_io_arbiter_rr.sv
// Round-robin selector: picks the lowest requesting index at or after ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    localparam int CW = IW + 1;

    logic [CW-1:0] cand [N_REQ];

    // cand[k] is the requester examined k places after ptr, already wrapped
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [CW-1:0] sum;
            assign sum       = {1'b0, ptr} + CW'(gi);
            assign cand[gi]  = (sum >= CW'(N_REQ)) ? (sum - CW'(N_REQ)) : sum;
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid && req[cand[k][IW-1:0]]) begin
                valid                    = 1'b1;
                idx                      = cand[k][IW-1:0];
                grant[cand[k][IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_io_arbiter.sv
// Arbitrates N_REQ requesters onto one DDR-style I/O pad pair: writes drive
// one cycle then turn around, reads clock the pad and capture din after RD_LAT.
module gb_io_arbiter
    import gb_io_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      we,
    input  logic [16*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           rdata,
    output logic                  oen,
    output logic [7:0]            dout_0,
    output logic [7:0]            dout_1,
    output logic                  clk_en,
    output logic                  latch_in,
    input  logic [7:0]            din_0,
    input  logic [7:0]            din_1,
    output logic                  busy
);

    localparam int            IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    localparam logic [3:0]    LAST_CNT = 4'(RD_LAT);

    state_t             state_reg;
    logic [IW-1:0]      rr_ptr_reg;
    logic [IW-1:0]      idx_reg;
    logic [3:0]         cnt_reg;
    logic [3:0]         cnt_next;
    logic [N_REQ-1:0]   done_reg;
    logic [15:0]        rdata_reg;
    logic               oen_reg;
    logic               clk_en_reg;
    logic               latch_in_reg;
    logic               busy_reg;
    logic [7:0]         dout_0_reg;
    logic [7:0]         dout_1_reg;

    logic [N_REQ-1:0]   arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic               grant_go;
    logic [15:0]        wdata_arr [N_REQ];
    logic [15:0]        win_wdata;
    logic [N_REQ-1:0]   idx_onehot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wdata
            assign wdata_arr[gi] = wdata[gi*16 +: 16];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // The grant is decided and shown in the IDLE cycle itself so the pad
    // phase starts on the very next cycle.
    assign grant_go   = (state_reg == IDLE) && arb_valid && !rst;
    assign gnt        = grant_go ? arb_grant : '0;
    assign win_wdata  = wdata_arr[arb_idx];
    assign cnt_next   = cnt_reg + 4'd1;
    assign idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            done_reg     <= '0;
            rdata_reg    <= '0;
            oen_reg      <= 1'b0;
            clk_en_reg   <= 1'b0;
            latch_in_reg <= 1'b1;
            busy_reg     <= 1'b0;
            dout_0_reg   <= '0;
            dout_1_reg   <= '0;
        end else begin
            done_reg <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (grant_go) begin
                        idx_reg      <= arb_idx;
                        rr_ptr_reg   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                        latch_in_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        clk_en_reg   <= 1'b1;
                        if (we[arb_idx]) begin
                            state_reg  <= DRIVE;
                            oen_reg    <= 1'b1;
                            dout_0_reg <= win_wdata[7:0];
                            dout_1_reg <= win_wdata[15:8];
                        end else begin
                            state_reg <= WAIT_RD;
                            cnt_reg   <= '0;
                        end
                    end
                end
                DRIVE: begin
                    state_reg  <= TURN;
                    oen_reg    <= 1'b0;
                    clk_en_reg <= 1'b0;
                end
                TURN: begin
                    state_reg    <= DONE;
                    done_reg     <= idx_onehot;
                    latch_in_reg <= 1'b1;
                end
                WAIT_RD: begin
                    // Clock enable covers RD_LAT cycles; the extra cycle
                    // after it is where din is valid and gets captured.
                    if (cnt_reg == LAST_CNT) begin
                        state_reg    <= DONE;
                        rdata_reg    <= {din_1, din_0};
                        done_reg     <= idx_onehot;
                        latch_in_reg <= 1'b1;
                    end else begin
                        cnt_reg    <= cnt_next;
                        clk_en_reg <= (cnt_next < LAST_CNT);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign oen      = oen_reg;
    assign clk_en   = clk_en_reg;
    assign latch_in = latch_in_reg;
    assign busy     = busy_reg;
    assign dout_0   = dout_0_reg;
    assign dout_1   = dout_1_reg;

endmodule

// File: tb/tb_gb_io_arbiter.sv
// Scoreboard bench for gb_io_arbiter: a transaction-level model predicts
// grants, done timing and read data; a negedge monitor compares the DUT.
module tb_gb_io_arbiter;

    localparam int N    = 4;
    localparam int RL   = 2;
    localparam int MAXC = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [16*N-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [15:0]     rdata;
    logic            oen;
    logic [7:0]      dout_0;
    logic [7:0]      dout_1;
    logic            clk_en;
    logic            latch_in;
    logic [7:0]      din_0;
    logic [7:0]      din_1;
    logic            busy;

    gb_io_arbiter #(.N_REQ(N), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .oen(oen),
        .dout_0(dout_0), .dout_1(dout_1), .clk_en(clk_en),
        .latch_in(latch_in), .din_0(din_0), .din_1(din_1), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad input data is a per-cycle table so the model knows din in advance
    logic [15:0] din_tab [MAXC];
    assign {din_1, din_0} = din_tab[cyc % MAXC];

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] wd;
        logic [15:0] rd;
        int          g_cyc;
        int          d_cyc;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    bit          have_cur = 1'b0;
    bit          mon_en = 1'b0;
    int          m_ptr = 0;
    int          m_free = 0;
    logic [15:0] last_rd = '0;
    int          n_txn = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp_v);
        end
    endtask

    // One bus cycle of stimulus plus the reference model's view of it.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                        input logic [16*N-1:0] wd);
        int   win;
        txn_t t;
        @(posedge clk);
        #1;
        req   = r;
        we    = w;
        wdata = wd;
        win   = -1;
        if (cyc >= m_free && r != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && r[c]) win = c;
            end
            t.idx   = win;
            t.wr    = w[win];
            t.wd    = wd[win*16 +: 16];
            t.g_cyc = cyc;
            t.d_cyc = t.wr ? cyc + 3 : cyc + RL + 2;
            if (!t.wr) last_rd = din_tab[(cyc + RL + 1) % MAXC];
            t.rd    = last_rd;
            m_free  = t.d_cyc + 1;
            m_ptr   = (win + 1) % N;
            exp_q.push_back(t);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt cyc=%0d actual=%b required=0", cyc, gnt);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("gnt_vec", 32'(gnt), 32'(1) << cur.idx);
                    chk("gnt_cycle", cyc, cur.g_cyc);
                    chk("gnt_busy", 32'(busy), 0);
                    chk("gnt_latch_in", 32'(latch_in), 1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].g_cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL gnt_missing cyc=%0d actual=0 required=%0d", cyc, exp_q[0].idx);
                void'(exp_q.pop_front());
            end

            if (have_cur && cyc > cur.g_cyc && cyc < cur.d_cyc) begin
                chk("busy_active", 32'(busy), 1);
                chk("latch_in_active", 32'(latch_in), 0);
                if (cur.wr) begin
                    chk("wr_oen", 32'(oen), (cyc == cur.g_cyc + 1) ? 1 : 0);
                    chk("wr_clk_en", 32'(clk_en), (cyc == cur.g_cyc + 1) ? 1 : 0);
                    chk("wr_dout", 32'({dout_1, dout_0}), 32'(cur.wd));
                end else begin
                    chk("rd_oen", 32'(oen), 0);
                    chk("rd_clk_en", 32'(clk_en), (cyc <= cur.g_cyc + RL) ? 1 : 0);
                end
            end

            if (done != '0) begin
                if (!have_cur) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d actual=%b required=0", cyc, done);
                end else begin
                    chk("done_vec", 32'(done), 32'(1) << cur.idx);
                    chk("done_cycle", cyc, cur.d_cyc);
                    chk("done_rdata", 32'(rdata), 32'(cur.rd));
                    chk("done_latch_in", 32'(latch_in), 1);
                    chk("done_pads", 32'({oen, clk_en}), 0);
                    n_txn++;
                    $display("txn %0d idx=%0d %s wdata=%h rdata=%h gnt@%0d done@%0d",
                             n_txn, cur.idx, cur.wr ? "WR" : "RD", cur.wd, rdata,
                             cur.g_cyc, cyc);
                    have_cur = 1'b0;
                end
            end else if (have_cur && cyc == cur.d_cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missing cyc=%0d actual=0 required=%0d", cyc, cur.idx);
                have_cur = 1'b0;
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < MAXC; i++) din_tab[i] = 16'($urandom);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_oen", 32'(oen), 0);
        chk("rst_clk_en", 32'(clk_en), 0);
        chk("rst_dout", 32'({dout_1, dout_0}), 0);
        chk("rst_latch_in", 32'(latch_in), 1);
        chk("rst_busy", 32'(busy), 0);

        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr  = 0;
        m_free = 0;
        mon_en = 1'b1;

        // single write to requester 0
        step(4'b0001, 4'b0001, {48'h0, 16'hA55A});
        repeat (5) step('0, '0, '0);

        // single read from requester 2 with a known pad word
        din_tab[(cyc + 1 + RL + 1) % MAXC] = 16'h3CC3;
        step(4'b0100, 4'b0000, '0);
        repeat (6) step('0, '0, '0);

        // all requesters held high: strict rotation expected
        repeat (24) step(4'hF, 4'($urandom), {$urandom, $urandom});

        // short pulse while busy is ignored; drop right after grant still completes
        step(4'b0001, 4'b0001, {$urandom, $urandom});
        step(4'b0010, 4'b0000, '0);
        repeat (4) step('0, '0, '0);
        step(4'b0010, 4'b0000, '0);
        repeat (6) step('0, '0, '0);

        for (int i = 0; i < 1500; i++) begin
            r = ((i % 300) < 150) ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
            step(r, 4'($urandom), {$urandom, $urandom});
        end
        repeat (12) step('0, '0, '0);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_pending", 32'(have_cur), 0);

        // reset during the drive phase aborts without a done pulse
        mon_en = 1'b0;
        step(4'b0100, 4'b0100, {16'h0, 16'h1234, 32'h0});
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("abort_drive_oen", 32'(oen), 1);
        chk("abort_drive_dout", 32'({dout_1, dout_0}), 32'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("abort_oen", 32'(oen), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_latch_in", 32'(latch_in), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end
        @(posedge clk);
        #1 req = 4'hF;
        @(negedge clk);
        chk("abort_ptr_reset", 32'(gnt), 32'h1);
        @(posedge clk);
        #1 req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
